// File: rtl/one_bit_adder_half_adder.sv
// Half adder leaf cell: sum and carry of two single bits.
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y;
    assign carry = x & y;

endmodule

// File: rtl/one_bit_adder.sv
// Single-bit full adder built from two half adders, with a combinational
// result and a registered copy of it for pipelined users.
module one_bit_adder (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout,
    output logic s_q,
    output logic cout_q
);

    logic sum_ab_s;
    logic carry_ab_s;
    logic carry_c_s;
    logic s_r;
    logic cout_r;

    half_adder u_ha_ab (
        .x     (a),
        .y     (b),
        .sum   (sum_ab_s),
        .carry (carry_ab_s)
    );

    half_adder u_ha_c (
        .x     (sum_ab_s),
        .y     (cin),
        .sum   (s),
        .carry (carry_c_s)
    );

    // At most one of the two carries can be set, so OR yields the majority.
    assign cout = carry_ab_s | carry_c_s;

    // Output register: captures the combinational result on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r    <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            s_r    <= s;
            cout_r <= cout;
        end
    end

    assign s_q    = s_r;
    assign cout_q = cout_r;

endmodule

// File: tb/tb_one_bit_adder.sv
// Directed self-checking bench for one_bit_adder.
module tb_one_bit_adder;

    logic clk;
    logic clk_en;
    logic rst_n;
    logic a;
    logic b;
    logic cin;
    logic s;
    logic cout;
    logic s_q;
    logic cout_q;

    int n_checks;
    int n_errors;

    // Hand-computed {cout,s} indexed by {a,b,cin}.
    logic [1:0] exp_tab [8];

    one_bit_adder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .cout   (cout),
        .s_q    (s_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;

    // Clock runs only while clk_en is set.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic apply(input logic [2:0] v);
        a   = v[2];
        b   = v[1];
        cin = v[0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] prev;
        n_checks = 0;
        n_errors = 0;
        exp_tab[0] = 2'b00;
        exp_tab[1] = 2'b01;
        exp_tab[2] = 2'b01;
        exp_tab[3] = 2'b10;
        exp_tab[4] = 2'b01;
        exp_tab[5] = 2'b10;
        exp_tab[6] = 2'b10;
        exp_tab[7] = 2'b11;

        clk_en = 1'b0;
        rst_n  = 1'b0;
        apply(3'b000);
        #1;
        check("reset_regs", {cout_q, s_q}, 2'b00);
        check("reset_comb_000", {cout, s}, 2'b00);

        // Combinational path with no clock and reset held.
        apply(3'b111);
        #1;
        check("comb_in_reset_111", {cout, s}, 2'b11);
        check("regs_in_reset_111", {cout_q, s_q}, 2'b00);

        // Exhaustive combinational sweep.
        for (int i = 0; i < 8; i++) begin
            apply(3'(i));
            #1;
            check($sformatf("comb_%0d", i), {cout, s}, exp_tab[i]);
        end

        // Start clock, capture 1,1,1, then reset between edges.
        rst_n  = 1'b1;
        clk_en = 1'b1;
        apply(3'b111);
        @(posedge clk);
        #1;
        check("capture_111", {cout_q, s_q}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {cout_q, s_q}, 2'b00);
        check("comb_during_reset", {cout, s}, 2'b11);

        // Release reset with 0,1,1 and capture on the next edge.
        apply(3'b011);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_edge_after_release", {cout_q, s_q}, 2'b00);
        @(posedge clk);
        #1;
        check("first_edge_011", {cout_q, s_q}, 2'b10);

        // Registered outputs lag the combinational result by one cycle.
        prev = 2'b10;
        for (int i = 0; i < 8; i++) begin
            apply(3'(i));
            #1;
            check($sformatf("seq_comb_%0d", i), {cout, s}, exp_tab[i]);
            check($sformatf("seq_hold_%0d", i), {cout_q, s_q}, prev);
            @(posedge clk);
            #1;
            check($sformatf("seq_reg_%0d", i), {cout_q, s_q}, exp_tab[i]);
            prev = exp_tab[i];
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
